// File: rtl/alu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_if
// Description : Operand/result bundle between the execute stage and the
//               ALU with multiply/divide engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [4:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             start;
    logic [WIDTH-1:0] ALUOut;
    logic             ZERO;
    logic             OVF;
    logic             busy;
    logic             done;
    logic             dz;
    logic             stall;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output ALUControl, SrcA, SrcB, start,
        input  ALUOut, ZERO, OVF, busy, done, dz, stall, hi_o, lo_o
    );

    modport slave (
        input  ALUControl, SrcA, SrcB, start,
        output ALUOut, ZERO, OVF, busy, done, dz, stall, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_muldiv_unit
// Description : Combinational ALU plus iterative multiply/divide engine with
//               HI/LO registers and start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic     clk,
    input  wire logic     rst,
    alu_muldiv_if.slave   bus
);
    localparam logic [1:0]     c_idle = 2'd0;
    localparam logic [1:0]     c_run  = 2'd1;
    localparam logic [1:0]     c_fix  = 2'd2;
    localparam logic [SHW-1:0] c_last = SHW'(WIDTH - 1);

    logic [1:0]       r_state, w_next;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_hi, r_lo;
    logic             r_done, r_dz;
    logic [WIDTH-1:0] r_ph, r_pl, r_opb, r_dvd;
    logic [1:0]       r_kind;
    logic             r_neg_q, r_neg_r;

    logic [4:0]       w_op;
    logic [WIDTH-1:0] w_a, w_b, w_sum, w_diff, w_alu;
    logic [SHW-1:0]   w_shamt;
    logic             w_ovf, w_busy_state, w_accept, w_seq_op;
    logic             w_sgn, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_mag_a, w_mag_b;
    logic [WIDTH:0]   w_madd, w_rs, w_dsub;
    logic             w_dge;
    logic [2*WIDTH-1:0] w_prod_mag, w_prod;
    logic [WIDTH-1:0] w_quo, w_rem, w_fix_hi, w_fix_lo;
    logic             w_divz;

    assign w_op    = bus.ALUControl;
    assign w_a     = bus.SrcA;
    assign w_b     = bus.SrcB;
    assign w_sum   = w_a + w_b;
    assign w_diff  = w_a - w_b;
    assign w_shamt = w_a[SHW-1:0];

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (w_op)
            5'd0:  w_alu = w_b;
            5'd1: begin
                w_alu = w_sum;
                w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            5'd2: begin
                w_alu = w_diff;
                w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            5'd3:  w_alu = w_a | w_b;
            5'd4:  w_alu = w_a & w_b;
            5'd5:  w_alu = w_a ^ w_b;
            5'd6:  w_alu = ~(w_a | w_b);
            5'd7:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            5'd8:  w_alu = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
            5'd9:  w_alu = w_b << w_shamt;
            5'd10: w_alu = w_b >> w_shamt;
            5'd11: w_alu = $signed(w_b) >>> w_shamt;
            5'd16: w_alu = r_hi;
            5'd17: w_alu = r_lo;
            default: w_alu = '0;
        endcase
    end

    // Operand magnitudes; signed kinds have ALUControl[0] clear
    assign w_sgn    = ~w_op[0];
    assign w_a_neg  = w_sgn & w_a[WIDTH-1];
    assign w_b_neg  = w_sgn & w_b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? (~w_a + 1'b1) : w_a;
    assign w_mag_b  = w_b_neg ? (~w_b + 1'b1) : w_b;
    assign w_seq_op = (w_op >= 5'd12) && (w_op <= 5'd19);
    assign w_accept = (r_state == c_idle) && bus.start && (w_op >= 5'd12) && (w_op <= 5'd15);

    // One iteration: shift-add multiply / restoring divide
    assign w_madd = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    assign w_rs   = {r_ph, r_pl[WIDTH-1]};
    assign w_dge  = (w_rs >= {1'b0, r_opb});
    assign w_dsub = w_rs - {1'b0, r_opb};

    assign w_prod_mag = {r_ph, r_pl};
    assign w_prod     = r_neg_q ? (~w_prod_mag + 1'b1) : w_prod_mag;
    assign w_quo      = r_neg_q ? (~r_pl + 1'b1) : r_pl;
    assign w_rem      = r_neg_r ? (~r_ph + 1'b1) : r_ph;
    assign w_divz     = (r_opb == '0);

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (r_kind[1]) begin
            if (w_divz) begin
                w_fix_hi = r_dvd;
                w_fix_lo = (!r_kind[0] && r_dvd[WIDTH-1]) ? {{(WIDTH-1){1'b0}}, 1'b1} : '1;
            end else begin
                w_fix_hi = w_rem;
                w_fix_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_idle;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:  if (w_accept) w_next = c_run;
            c_run:   if (r_cnt == c_last) w_next = c_fix;
            c_fix:   w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        w_busy_state = (r_state != c_idle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_cnt   <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
            r_opb   <= '0;
            r_dvd   <= '0;
            r_kind  <= 2'd0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_kind  <= w_op[1:0];
                r_cnt   <= '0;
                r_dz    <= 1'b0;
                r_ph    <= '0;
                r_pl    <= w_op[1] ? w_mag_a : w_mag_b;
                r_opb   <= w_op[1] ? w_mag_b : w_mag_a;
                r_dvd   <= w_a;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
            end else if (r_state == c_run) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_kind[1]) begin
                    r_ph <= w_dge ? w_dsub[WIDTH-1:0] : w_rs[WIDTH-1:0];
                    r_pl <= {r_pl[WIDTH-2:0], w_dge};
                end else begin
                    r_ph <= w_madd[WIDTH:1];
                    r_pl <= {w_madd[0], r_pl[WIDTH-1:1]};
                end
            end else if (r_state == c_fix) begin
                r_done <= 1'b1;
                r_hi   <= w_fix_hi;
                r_lo   <= w_fix_lo;
                r_dz   <= r_kind[1] & w_divz;
            end else if ((r_state == c_idle) && bus.start) begin
                if (w_op == 5'd18) r_hi <= w_a;
                if (w_op == 5'd19) r_lo <= w_a;
            end
        end
    end

    assign bus.ALUOut = w_alu;
    assign bus.ZERO   = (w_alu == '0);
    assign bus.OVF    = w_ovf;
    // busy also covers the cycle in which a new op is being accepted
    assign bus.busy   = w_busy_state | w_accept;
    assign bus.done   = r_done;
    assign bus.dz     = r_dz;
    assign bus.stall  = (w_busy_state | w_accept) & w_seq_op;
    assign bus.hi_o   = r_hi;
    assign bus.lo_o   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_muldiv_unit
// Description : Directed self-checking bench for alu_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    alu_muldiv_if #(.WIDTH(32)) bus ();

    alu_muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an op with a one-cycle start pulse and measures cycles to done
    task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        bus.ALUControl = op;
        bus.SrcA = a;
        bus.SrcB = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.ALUControl = 5'd0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.dz !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", bus.dz); end
        total++; if (bus.hi_o !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi_o); end
        total++; if (bus.lo_o !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo_o); end
    endtask

    task automatic test_comb();
        bus.ALUControl = 5'd1; bus.SrcA = 32'h7FFF_FFFF; bus.SrcB = 32'h1; #1;
        total++; if (bus.ALUOut !== 32'h8000_0000) begin bad++; $display("FAIL add_out got=%h want=80000000", bus.ALUOut); end
        total++; if (bus.OVF !== 1'b1) begin bad++; $display("FAIL add_ovf got=%b want=1", bus.OVF); end
        bus.ALUControl = 5'd2; bus.SrcA = 32'd5; bus.SrcB = 32'd5; #1;
        total++; if (bus.ALUOut !== 32'h0 || bus.ZERO !== 1'b1) begin bad++; $display("FAIL sub_zero got=%h/%b want=0/1", bus.ALUOut, bus.ZERO); end
        total++; if (bus.OVF !== 1'b0) begin bad++; $display("FAIL sub_ovf got=%b want=0", bus.OVF); end
        bus.ALUControl = 5'd2; bus.SrcA = 32'h8000_0000; bus.SrcB = 32'd1; #1;
        total++; if (bus.ALUOut !== 32'h7FFF_FFFF || bus.OVF !== 1'b1) begin bad++; $display("FAIL sub_ovf2 got=%h/%b want=7fffffff/1", bus.ALUOut, bus.OVF); end
        bus.ALUControl = 5'd7; bus.SrcA = 32'hFFFF_FFFF; bus.SrcB = 32'd1; #1;
        total++; if (bus.ALUOut !== 32'd1) begin bad++; $display("FAIL slt got=%h want=1", bus.ALUOut); end
        bus.ALUControl = 5'd8; #1;
        total++; if (bus.ALUOut !== 32'd0) begin bad++; $display("FAIL sltu got=%h want=0", bus.ALUOut); end
        bus.ALUControl = 5'd11; bus.SrcA = 32'd4; bus.SrcB = 32'h8000_0000; #1;
        total++; if (bus.ALUOut !== 32'hF800_0000) begin bad++; $display("FAIL sra got=%h want=f8000000", bus.ALUOut); end
        bus.ALUControl = 5'd10; #1;
        total++; if (bus.ALUOut !== 32'h0800_0000) begin bad++; $display("FAIL srl got=%h want=08000000", bus.ALUOut); end
        bus.ALUControl = 5'd9; bus.SrcA = 32'd35; bus.SrcB = 32'h0000_0003; #1;
        total++; if (bus.ALUOut !== 32'h0000_0018) begin bad++; $display("FAIL sll got=%h want=00000018", bus.ALUOut); end
        bus.ALUControl = 5'd6; bus.SrcA = 32'hF0F0_0000; bus.SrcB = 32'h0000_0F0F; #1;
        total++; if (bus.ALUOut !== 32'h0F0F_F0F0) begin bad++; $display("FAIL nor got=%h want=0f0ff0f0", bus.ALUOut); end
        bus.ALUControl = 5'd0; #1;
        total++; if (bus.ALUOut !== 32'h0000_0F0F) begin bad++; $display("FAIL none got=%h want=00000f0f", bus.ALUOut); end
        bus.ALUControl = 5'd25; #1;
        total++; if (bus.ALUOut !== 32'h0 || bus.OVF !== 1'b0) begin bad++; $display("FAIL undef_op got=%h want=0", bus.ALUOut); end
        bus.ALUControl = 5'd0;
        tick();
    endtask

    task automatic test_mul();
        int lat;
        do_op(5'd12, 32'hFFFF_FFFD, 32'd7, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL mult_latency got=%0d want=33", lat); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mult_busy_done got=%b want=0", bus.busy); end
        total++; if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_res got=%h_%h want=ffffffff_ffffffeb", bus.hi_o, bus.lo_o); end
        tick();
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL done_width got=%b want=0", bus.done); end
        do_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL multu_latency got=%0d want=33", lat); end
        total++; if (bus.hi_o !== 32'hFFFF_FFFE || bus.lo_o !== 32'h0000_0001) begin bad++; $display("FAIL multu_res got=%h_%h want=fffffffe_00000001", bus.hi_o, bus.lo_o); end
        tick();
    endtask

    task automatic test_div();
        int lat;
        do_op(5'd14, 32'hFFFF_FFF9, 32'd2, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL div_latency got=%0d want=33", lat); end
        total++; if (bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_res got=hi %h lo %h want=hi ffffffff lo fffffffd", bus.hi_o, bus.lo_o); end
        total++; if (bus.dz !== 1'b0) begin bad++; $display("FAIL div_dz got=%b want=0", bus.dz); end
        tick();
        do_op(5'd15, 32'd7, 32'd0, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL divu0_latency got=%0d want=33", lat); end
        total++; if (bus.dz !== 1'b1) begin bad++; $display("FAIL divu0_dz got=%b want=1", bus.dz); end
        total++; if (bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'd7) begin bad++; $display("FAIL divu0_res got=hi %h lo %h want=hi 00000007 lo ffffffff", bus.hi_o, bus.lo_o); end
        tick();
        total++; if (bus.dz !== 1'b1) begin bad++; $display("FAIL dz_sticky got=%b want=1", bus.dz); end
        do_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        total++; if (bus.dz !== 1'b0) begin bad++; $display("FAIL dz_cleared got=%b want=0", bus.dz); end
        total++; if (bus.lo_o !== 32'h8000_0000 || bus.hi_o !== 32'h0) begin bad++; $display("FAIL div_minneg got=hi %h lo %h want=hi 0 lo 80000000", bus.hi_o, bus.lo_o); end
        tick();
        do_op(5'd14, 32'hFFFF_FFF8, 32'd0, lat);
        total++; if (bus.dz !== 1'b1 || bus.lo_o !== 32'h1 || bus.hi_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL div0_neg got=dz %b hi %h lo %h want=dz 1 hi fffffff8 lo 1", bus.dz, bus.hi_o, bus.lo_o); end
        tick();
        do_op(5'd15, 32'd100, 32'd7, lat);
        total++; if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin bad++; $display("FAIL divu_res got=hi %h lo %h want=hi 2 lo e", bus.hi_o, bus.lo_o); end
        tick();
    endtask

    task automatic test_busy_interactions();
        int lat;
        bus.ALUControl = 5'd19; bus.SrcA = 32'h1234; bus.start = 1'b1; tick();
        bus.ALUControl = 5'd18; bus.SrcA = 32'h5555; tick();
        bus.start = 1'b0; bus.ALUControl = 5'd0;
        total++; if (bus.lo_o !== 32'h1234 || bus.hi_o !== 32'h5555) begin bad++; $display("FAIL mthi_mtlo got=hi %h lo %h want=hi 5555 lo 1234", bus.hi_o, bus.lo_o); end
        bus.ALUControl = 5'd12; bus.SrcA = 32'd6; bus.SrcB = 32'd7; bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.ALUControl = 5'd0;
        lat = 0;
        repeat (3) begin tick(); lat++; end
        bus.ALUControl = 5'd17; #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL mflo_stall got=%b want=1", bus.stall); end
        total++; if (bus.ALUOut !== 32'h1234) begin bad++; $display("FAIL mflo_busy got=%h want=00001234", bus.ALUOut); end
        bus.ALUControl = 5'd1; #1;
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL add_no_stall got=%b want=0", bus.stall); end
        bus.ALUControl = 5'd12; bus.SrcA = 32'd100; bus.SrcB = 32'd100; bus.start = 1'b1; tick(); lat++;
        bus.ALUControl = 5'd18; bus.SrcA = 32'hDEAD; tick(); lat++;
        bus.start = 1'b0; bus.ALUControl = 5'd0;
        total++; if (bus.hi_o !== 32'h5555) begin bad++; $display("FAIL mthi_busy got=%h want=00005555", bus.hi_o); end
        while (!bus.done && lat < 40) begin tick(); lat++; end
        total++; if (lat !== 33) begin bad++; $display("FAIL held_latency got=%0d want=33", lat); end
        total++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'd42) begin bad++; $display("FAIL held_res got=hi %h lo %h want=hi 0 lo 2a", bus.hi_o, bus.lo_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int pulses;
        bus.ALUControl = 5'd14; bus.SrcA = 32'd100; bus.SrcB = 32'd3; bus.start = 1'b1; tick();
        bus.start = 1'b0; bus.ALUControl = 5'd0;
        repeat (10) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL midrst_flags got=busy %b done %b want=0 0", bus.busy, bus.done); end
        total++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin bad++; $display("FAIL midrst_hilo got=%h_%h want=0_0", bus.hi_o, bus.lo_o); end
        pulses = 0;
        repeat (40) begin tick(); if (bus.done) pulses++; end
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_done got=%0d pulses want=0", pulses); end
        do_op(5'd12, 32'd5, 32'hFFFF_FFFE, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL postrst_latency got=%0d want=33", lat); end
        total++; if (bus.hi_o !== 32'hFFFF_FFFF || bus.lo_o !== 32'hFFFF_FFF6) begin bad++; $display("FAIL postrst_res got=%h_%h want=ffffffff_fffffff6", bus.hi_o, bus.lo_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(5'd14, 32'd100, 32'd7, lat);
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_first_latency got=%0d want=33", lat); end
        bus.ALUControl = 5'd13; bus.SrcA = 32'hFFFF_0000; bus.SrcB = 32'h10; bus.start = 1'b1; #1;
        total++; if (bus.done !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_overlap got=done %b busy %b want=1 1", bus.done, bus.busy); end
        total++; if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin bad++; $display("FAIL b2b_first_res got=hi %h lo %h want=hi 2 lo e", bus.hi_o, bus.lo_o); end
        tick();
        bus.start = 1'b0; bus.ALUControl = 5'd0;
        total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL b2b_accepted got=busy %b done %b want=1 0", bus.busy, bus.done); end
        lat = 0;
        while (!bus.done && lat < 40) begin tick(); lat++; end
        total++; if (lat !== 33) begin bad++; $display("FAIL b2b_second_latency got=%0d want=33", lat); end
        total++; if (bus.hi_o !== 32'h0000_000F || bus.lo_o !== 32'hFFF0_0000) begin bad++; $display("FAIL b2b_second_res got=%h_%h want=0000000f_fff00000", bus.hi_o, bus.lo_o); end
        tick();
    endtask

    initial begin
        bus.ALUControl = 5'd0;
        bus.SrcA = 32'h0;
        bus.SrcB = 32'h0;
        bus.start = 1'b0;
        test_reset();
        test_comb();
        test_mul();
        test_div();
        test_busy_interactions();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
